// File: rtl/spu_rotate_mask_unit_if.sv
// Operand/result bundle between the even-pipe operand latch, the
// rotate-and-mask unit and the forwarding/writeback path.
interface spu_rotate_mask_unit_if #(
  parameter int TAG_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [TAG_W-1:0] rt_tag;
  logic [127:0]     register_RA;
  logic [127:0]     register_RB;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [127:0]     register_RT;

  modport master (
    output in_valid, op, rt_tag, register_RA, register_RB, stall, flush,
    input  in_ready, out_valid, out_tag, register_RT
  );

  modport slave (
    input  in_valid, op, rt_tag, register_RA, register_RB, stall, flush,
    output in_ready, out_valid, out_tag, register_RT
  );
endinterface

// File: rtl/spu_rotate_mask_unit.sv
// Pipelined right shift for rotmh/rotm/rotmah/rotma (zero or sign fill),
// carrying the destination tag, with stall and flush.
module spu_rotate_mask_unit #(
  parameter int STAGES = 4,
  parameter int TAG_W  = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  spu_rotate_mask_unit_if.slave bus
);

  // op[0] selects word elements, op[1] selects sign fill
  function automatic logic [4:0] f_cnt_h(input logic [15:0] rb);
    logic [15:0] neg;
    neg = 16'd0 - rb;
    return neg[4:0];
  endfunction

  function automatic logic [5:0] f_cnt_w(input logic [31:0] rb);
    logic [31:0] neg;
    neg = 32'd0 - rb;
    return neg[5:0];
  endfunction

  function automatic logic [127:0] f_shift(input logic [1:0]   op,
                                           input logic [127:0] ra,
                                           input logic [39:0]  cnt_h,
                                           input logic [23:0]  cnt_w);
    logic [127:0] res;
    logic [15:0]  h;
    logic [31:0]  w;
    logic [4:0]   ch;
    logic [5:0]   cw;
    res = '0;
    if (op[0]) begin
      for (int i = 0; i < 4; i++) begin
        w  = ra[32*i +: 32];
        cw = cnt_w[6*i +: 6];
        if (cw[5])
          res[32*i +: 32] = {32{op[1] & w[31]}};
        else if (op[1])
          res[32*i +: 32] = $signed(w) >>> cw[4:0];
        else
          res[32*i +: 32] = w >> cw[4:0];
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        h  = ra[16*i +: 16];
        ch = cnt_h[5*i +: 5];
        if (ch[4])
          res[16*i +: 16] = {16{op[1] & h[15]}};
        else if (op[1])
          res[16*i +: 16] = $signed(h) >>> ch[3:0];
        else
          res[16*i +: 16] = h >> ch[3:0];
      end
    end
    return res;
  endfunction

  logic [39:0]  w_cnt_h_in;
  logic [23:0]  w_cnt_w_in;
  logic [127:0] w_res_next;

  always_comb begin
    w_cnt_h_in = '0;
    w_cnt_w_in = '0;
    for (int i = 0; i < 8; i++)
      w_cnt_h_in[5*i +: 5] = f_cnt_h(bus.register_RB[16*i +: 16]);
    for (int i = 0; i < 4; i++)
      w_cnt_w_in[6*i +: 6] = f_cnt_w(bus.register_RB[32*i +: 32]);
  end

  // Stage 1 payload: shifted result for the 2-deep pipe, else operands + counts
  generate
    if (STAGES == 2) begin : g_direct
      logic [127:0] r_s1_res;

      always_ff @(posedge clk) begin
        if (reset)
          r_s1_res <= '0;
        else if (!bus.stall)
          r_s1_res <= f_shift(bus.op, bus.register_RA, w_cnt_h_in, w_cnt_w_in);
      end

      assign w_res_next = r_s1_res;
    end else begin : g_split
      logic [1:0]   r_op;
      logic [127:0] r_ra;
      logic [39:0]  r_cnt_h;
      logic [23:0]  r_cnt_w;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_op    <= '0;
          r_ra    <= '0;
          r_cnt_h <= '0;
          r_cnt_w <= '0;
        end else if (!bus.stall) begin
          r_op    <= bus.op;
          r_ra    <= bus.register_RA;
          r_cnt_h <= w_cnt_h_in;
          r_cnt_w <= w_cnt_w_in;
        end
      end

      assign w_res_next = f_shift(r_op, r_ra, r_cnt_h, r_cnt_w);
    end
  endgenerate

  logic [STAGES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [127:0]      r_res [STAGES-1];

  // Flush clears only valids; data left behind is never qualified
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++)
        r_tag[s] <= '0;
      for (int s = 0; s < STAGES - 1; s++)
        r_res[s] <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (!bus.stall) begin
      r_valid  <= {r_valid[STAGES-2:0], bus.in_valid};
      r_tag[0] <= bus.rt_tag;
      for (int s = 1; s < STAGES; s++)
        r_tag[s] <= r_tag[s-1];
      r_res[0] <= w_res_next;
      for (int s = 1; s < STAGES - 1; s++)
        r_res[s] <= r_res[s-1];
    end
  end

  assign bus.in_ready    = !bus.stall;
  assign bus.out_valid   = r_valid[STAGES-1];
  assign bus.out_tag     = r_tag[STAGES-1];
  assign bus.register_RT = r_res[STAGES-2];

endmodule

// File: doc/spu_rotate_mask_unit.md
Name: spu_rotate_mask_unit

Overview:
- Pipelined SPU even-pipe right-shift unit for the rotate-and-mask family: rotmh, rotm, rotmah, rotma.
- Companion to the left-rotate word/halfword logic; covers the opposite shift direction, with logical (zero) or arithmetic (sign) fill.
- Sits between the even-pipe operand latch and the result forwarding/writeback path.
- Carries the destination register tag alongside the data; supports stall and flush from the issue/branch logic.

Parameters:
- STAGES, 4, pipeline depth from input capture to out_valid; legal range 2..6.
- TAG_W, 7, width of the destination register tag (128 SPU registers).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- in_valid, input, 1, operation present on the inputs this cycle.
- in_ready, output, 1, unit accepts input; equals !stall.
- op, input, 2, 00 rotmh, 01 rotm, 10 rotmah, 11 rotma.
- rt_tag, input, TAG_W, destination register number.
- register_RA, input, 128, source operand; byte 0 is bits [127:120].
- register_RB, input, 128, per-element shift-count operand.
- stall, input, 1, freezes every stage.
- flush, input, 1, kills all in-flight operations.
- out_valid, output, 1, result valid.
- out_tag, output, TAG_W, tag of the result.
- register_RT, output, 128, result.

Behaviour:
- Reset: on posedge clk with reset=1, all stage valids clear. out_valid=0, out_tag=0, register_RT=0. Reset overrides stall and flush.
- Capture: on posedge with in_valid && !stall, stage 1 loads op, rt_tag, RA and RB.
- Latency: the result appears exactly STAGES cycles after capture when no stall occurs. Issue rate is 1 per cycle.
- Stall: while stall=1, all stage registers and the outputs hold their values, including out_valid.
- Flush: on posedge with flush=1, all stage valids and out_valid clear in the same edge. Data registers are don't-care.
  - Flush wins over stall.
  - An input presented in the same cycle as flush is dropped.
- Halfword ops (rotmh, rotmah):
  - 8 independent elements; each element's count comes from the same halfword of RB.
  - cnt = (0 − RB_h) & 0x1F, a 5-bit value.
  - rotmh: cnt<16 gives RA_h >> cnt with zero fill; cnt≥16 gives 0x0000.
  - rotmah: cnt<16 gives an arithmetic shift; cnt≥16 gives 0xFFFF if RA_h[15]=1, else 0x0000.
- Word ops (rotm, rotma):
  - 4 elements; each element's count comes from the same word of RB.
  - cnt = (0 − RB_w) & 0x3F.
  - Threshold is 32; results otherwise follow the halfword rules scaled to 32 bits.
- Count negation is modulo 2^16 or 2^32 before masking; no overflow flags.
- Datapath split:
  - Stage 1 registers the operands and computes the counts.
  - Middle stages hold the shift result.
  - The last stage drives the outputs.
  - With STAGES=2, shift and count share stage 1.
- out_valid is high for one cycle per accepted operation, unless held by stall.
- Back-to-back operations produce out_valid high on consecutive cycles.

Test Plan:
1. rotmh, RA halfwords all 0x8001, RB halfwords all 0xFFFF (cnt=1) -> RT halfwords all 0x4000, out_valid exactly 4 cycles after capture, out_tag matches.
2. rotma, RA words 0x80000000, RB words 0xFFFFFFFC (cnt=4) -> 0xF8000000.
   - Same test with RB=0xFFFFFFE0 (cnt=32) -> rotm gives 0x00000000; rotma gives 0xFFFFFFFF.
3. RB=0 (cnt=0) for all four ops with RA=0x0123456789ABCDEF_FEDCBA9876543210 -> RT equals RA.
   - Also: rotmah with halfword 0x7FFF and cnt=20 -> 0x0000.
4. Issue 3 ops back-to-back; assert stall for 2 cycles while op1 is in stage 2 -> outputs frozen, no loss or duplication; results in order with tags 5, 6, 7.
5. Issue 2 ops, then flush while op2 is in stage 2, with stall=1 on the same cycle -> no out_valid for either op; a new op issued after the flush completes normally 4 cycles later.
6. Assert reset while 3 ops are in flight and stall=1 -> next cycle out_valid=0 and register_RT=0; no stale result ever emerges.
